// File: rtl/cic_comb_decimator_pkg.sv
// Shared defaults for the CIC comb/decimator datapath.
// Widths, stage count and rate width used as parameter defaults.
package cic_comb_decimator_pkg;

  localparam int CIC_IN_W   = 32;
  localparam int CIC_OUT_W  = 24;
  localparam int CIC_STAGES = 3;
  localparam int CIC_RATE_W = 8;

endpackage

// File: rtl/cic_comb_decimator_comb.sv
// One CIC comb stage: y = x - x[-1] on each valid sample.
// The delay register only advances on valid input.
module cic_comb
  import cic_comb_decimator_pkg::*;
#(
  parameter int WIDTH = CIC_IN_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_dly;
  logic [WIDTH-1:0] r_y;
  logic             r_vld;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dly <= '0;
      r_y   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_valid;
      if (i_valid) begin
        r_y   <= i_data - r_dly;
        r_dly <= i_data;
      end
    end
  end

  assign o_valid = r_vld;
  assign o_data  = r_y;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: rate counter, STAGES combs, output scaling.
// Define CIC_COMB_ROUND_EN for round-half-up with positive saturation.
module cic_comb_decimator
  import cic_comb_decimator_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_W,
  parameter int OUT_WIDTH = CIC_OUT_W,
  parameter int STAGES    = CIC_STAGES,
  parameter int RATE_W    = CIC_RATE_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_in_strobe,
  input  logic [IN_WIDTH-1:0]  i_in_data,
  input  logic [RATE_W-1:0]    i_decim_rate,
  output logic                 o_out_strobe,
  output logic [OUT_WIDTH-1:0] o_out_data
);

  localparam int SH = IN_WIDTH - OUT_WIDTH;

  logic [RATE_W-1:0]    r_cnt;
  logic [RATE_W-1:0]    w_last;
  logic                 w_dec;
  logic [IN_WIDTH-1:0]  r_cap;
  logic                 r_cap_vld;
  logic                 w_vld [STAGES+1];
  logic [IN_WIDTH-1:0]  w_dat [STAGES+1];
  logic [OUT_WIDTH-1:0] w_out;
  logic                 r_ostb;
  logic [OUT_WIDTH-1:0] r_odat;

  // Rates 0 and 1 both decimate on every strobe.
  assign w_last = (i_decim_rate == '0) ? '0
                : i_decim_rate - RATE_W'(1);
  assign w_dec  = i_in_strobe && (r_cnt >= w_last);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= w_dec;
      if (w_dec) begin
        r_cap <= i_in_data;
        r_cnt <= '0;
      end else if (i_in_strobe) begin
        r_cnt <= r_cnt + RATE_W'(1);
      end
    end
  end

  assign w_vld[0] = r_cap_vld;
  assign w_dat[0] = r_cap;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    cic_comb #(
      .WIDTH (IN_WIDTH)
    ) u_comb (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_valid (w_vld[k]),
      .i_data  (w_dat[k]),
      .o_valid (w_vld[k+1]),
      .o_data  (w_dat[k+1])
    );
  end

  if (SH == 0) begin : g_pass
    assign w_out = w_dat[STAGES];
  end else begin : g_scale
`ifdef CIC_COMB_ROUND_EN
    localparam logic [IN_WIDTH-1:0] HALF =
      IN_WIDTH'(1) << (SH - 1);
    logic [IN_WIDTH-1:0] w_sum;
    logic                w_ovf;
    assign w_sum = w_dat[STAGES] + HALF;
    // Only a non-negative value can overflow when adding +HALF.
    assign w_ovf = ~w_dat[STAGES][IN_WIDTH-1]
                 & w_sum[IN_WIDTH-1];
    assign w_out = w_ovf
                 ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                 : w_sum[IN_WIDTH-1 -: OUT_WIDTH];
`else
    assign w_out = w_dat[STAGES][IN_WIDTH-1 -: OUT_WIDTH];
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ostb <= 1'b0;
      r_odat <= '0;
    end else begin
      r_ostb <= w_vld[STAGES];
      if (w_vld[STAGES]) begin
        r_odat <= w_out;
      end
    end
  end

  assign o_out_strobe = r_ostb;
  assign o_out_data   = r_odat;

endmodule
